// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, mult/div busy holds, branch
// flushes, plus a saturating stall-cycle counter for performance debug.
// State advances on the falling clock edge, matching the PC and pipe regs.
module hazard_stall_ctrl #(
    parameter int REGAW  = 5,
    parameter int MD_LAT = 32,
    parameter int CNTW   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [REGAW-1:0] id_rs_i,
    input  logic [REGAW-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [REGAW-1:0] ex_rt_i,
    input  logic             id_md_start_i,
    input  logic             id_md_use_i,
    input  logic             ex_br_taken_i,
    output logic             stall_o,
    output logic             keep_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             md_busy_o,
    output logic             md_done_o,
    output logic [CNTW-1:0]  stall_cnt_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Busy window runs MD_LAT cycles: loaded with MD_LAT-1, done when it hits 0.
    localparam logic [7:0] MD_CNT_LOAD = 8'(MD_LAT - 1);
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_nxt_s;
    logic [7:0]      md_cnt_r;
    logic [7:0]      md_cnt_nxt_s;
    logic [CNTW-1:0] stall_cnt_r;

    logic lu_s;
    logic mdh_s;
    logic busy_s;
    logic done_s;
    logic stall_s;
    logic keep_s;
    logic if_id_flush_s;
    logic id_ex_flush_s;

    // $zero is never a real dependency, so a load into r0 never stalls.
    assign lu_s   = ex_memread_i & (ex_rt_i != {REGAW{1'b0}}) &
                    ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    assign busy_s = (state_r == BUSY);
    assign mdh_s  = busy_s & (id_md_use_i | id_md_start_i);

    // Prioritised hold/flush decode: branch beats mult/div hold beats load-use.
    always_comb begin
        stall_s       = 1'b0;
        keep_s        = 1'b0;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        if (ex_br_taken_i) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (mdh_s) begin
            keep_s        = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (lu_s) begin
            stall_s       = 1'b1;
            id_ex_flush_s = 1'b1;
        end else begin
            stall_s       = 1'b0;
            id_ex_flush_s = 1'b0;
        end
    end

    // Mult/div FSM next state; a stalled or squashed start is simply retried.
    always_comb begin
        state_nxt_s  = state_r;
        md_cnt_nxt_s = md_cnt_r;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (id_md_start_i & ~ex_br_taken_i & ~lu_s) begin
                    state_nxt_s  = BUSY;
                    md_cnt_nxt_s = MD_CNT_LOAD;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            BUSY: begin
                if (md_cnt_r == 8'd0) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    md_cnt_nxt_s = md_cnt_r - 8'd1;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                md_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // FSM state and busy-window counter registers.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r  <= IDLE;
            md_cnt_r <= 8'd0;
        end else begin
            state_r  <= state_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
        end
    end

    // Saturating count of held cycles; sticks at all-ones instead of wrapping.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_r <= {CNTW{1'b0}};
        end else if ((stall_s | keep_s) && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_o       = stall_s;
    assign keep_o        = keep_s;
    assign if_id_flush_o = if_id_flush_s;
    assign id_ex_flush_o = id_ex_flush_s;
    assign md_busy_o     = busy_s;
    assign md_done_o     = done_s;
    assign stall_cnt_o   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random
// traffic compared against a behavioural model of remaining busy cycles.
module tb_hazard_stall_ctrl;

    localparam int REGAW  = 5;
    localparam int MD_LAT = 4;
    localparam int CNTW   = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [REGAW-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic             id_uses_rt = 1'b0, ex_memread = 1'b0;
    logic             id_md_start = 1'b0, id_md_use = 1'b0, ex_br_taken = 1'b0;
    logic             stall, keep, if_id_flush, id_ex_flush, md_busy, md_done;
    logic [CNTW-1:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles of busy window still to run (0 = idle), stall count.
    int busy_left = 0;
    int sc_model  = 0;

    hazard_stall_ctrl #(.REGAW(REGAW), .MD_LAT(MD_LAT), .CNTW(CNTW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .id_md_start_i(id_md_start), .id_md_use_i(id_md_use),
        .ex_br_taken_i(ex_br_taken),
        .stall_o(stall), .keep_o(keep), .if_id_flush_o(if_id_flush),
        .id_ex_flush_o(id_ex_flush), .md_busy_o(md_busy), .md_done_o(md_done),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle at posedge, checks outputs vs model, advances model on negedge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert,
                        input logic ms, input logic mu, input logic br);
        logic lu, busy, mdh, e_st, e_kp, e_if, e_id;
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rt = ert;
        id_md_start = ms; id_md_use = mu; ex_br_taken = br;
        #1;
        lu   = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
        busy = (busy_left > 0);
        mdh  = busy && (mu || ms);
        e_if = br;
        e_kp = !br && mdh;
        e_st = !br && !mdh && lu;
        e_id = br || mdh || lu;
        chk("stall",       32'(stall),       32'(e_st));
        chk("keep",        32'(keep),        32'(e_kp));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_if));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e_id));
        chk("md_busy",     32'(md_busy),     32'(busy));
        chk("md_done",     32'(md_done),     32'(busy_left == 1));
        chk("stall_cnt",   32'(stall_cnt),   32'(sc_model));
        @(negedge clk);
        if ((e_st || e_kp) && sc_model < CNT_MAX) sc_model++;
        if (busy) busy_left--;
        else if (ms && !br && !lu) busy_left = MD_LAT;
        @(posedge clk);
    endtask

    initial begin
        // Reset state with all inputs low.
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_keep", 32'(keep), 32'd0);
        chk("rst_flush", 32'({if_id_flush, id_ex_flush}), 32'd0);
        chk("rst_busy", 32'({md_busy, md_done}), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Load-use on rs, then the released cycle: counter 0 -> 1.
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        // Load-use on rt only when rt is a source.
        step(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        // Load into $zero never stalls.
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        // Mult/div start, then mfhi held through the whole window and released.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MD_LAT + 2; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Start blocked by load-use, retried next cycle; then branch + lu + mdh together.
        step(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        step(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        step(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-busy: start, one busy cycle, then reset.
        for (int i = 0; i < MD_LAT; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_busy_left", 32'(busy_left), 32'(MD_LAT - 1));
        rst_n = 1'b0;
        #1;
        busy_left = 0;
        sc_model  = 0;
        chk("midrst_busy", 32'(md_busy), 32'd0);
        chk("midrst_done", 32'(md_done), 32'd0);
        chk("midrst_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst_hold", 32'({stall, keep, if_id_flush, id_ex_flush}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b1;
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Saturation: 2^CNTW+3 consecutive load-use cycles.
        for (int i = 0; i < (1 << CNTW) + 3; i++)
            step(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("sat_model", 32'(stall_cnt), 32'(CNT_MAX));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
